// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared state encoding and default widths for the serial Jacobi PE
package pe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_LOAD = 3'd2,
    ST_CALC = 3'd3,
    ST_OUT  = 3'd4
  } pe_state_t;

  localparam int DEF_W      = 8;
  localparam int DEF_ITER_W = 8;

endpackage

// File: rtl/pe_shift_in.sv
// rtl/pe_shift_in.sv - MSB-first serial-in shift register with enable and parallel load
module pe_shift_in
  import pe_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clka,
  input  logic         rst_n,
  input  logic         en,
  input  logic         din,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  // Parallel load wins over shifting so the solution copy can take u_new.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= {q[W-2:0], din};
    end
  end

endmodule

// File: rtl/pe_jacobi_serial.sv
// rtl/pe_jacobi_serial.sv - bit-serial Jacobi processing element with residue flag and serial readout
module pe_jacobi_serial
  import pe_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int TOL    = 0,
  parameter int ROUND  = 0,
  parameter int ITER_W = DEF_ITER_W
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              init,
  input  logic              init_bit,
  input  logic              start,
  input  logic              in_valid,
  input  logic              left,
  input  logic              top,
  input  logic              right,
  input  logic              down,
  input  logic              read_en,
  output logic              sol_bit,
  output logic              sol_valid,
  output logic              residue,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_cnt
);

  localparam int            CW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  pe_state_t       state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    l_q, t_q, r_q, d_q, sol;
  logic            nb_en;
  logic [W+1:0]    sum, sum_rnd;
  logic [W-1:0]    u_new;
  logic signed [W:0] diff;
  logic [W:0]      mag;

  assign nb_en = (state == ST_LOAD) && in_valid;

  pe_shift_in #(.W(W)) u_left  (.clka(clka), .rst_n(rst_n), .en(nb_en), .din(left),  .load(1'b0), .load_val('0), .q(l_q));
  pe_shift_in #(.W(W)) u_top   (.clka(clka), .rst_n(rst_n), .en(nb_en), .din(top),   .load(1'b0), .load_val('0), .q(t_q));
  pe_shift_in #(.W(W)) u_right (.clka(clka), .rst_n(rst_n), .en(nb_en), .din(right), .load(1'b0), .load_val('0), .q(r_q));
  pe_shift_in #(.W(W)) u_down  (.clka(clka), .rst_n(rst_n), .en(nb_en), .din(down),  .load(1'b0), .load_val('0), .q(d_q));

  // The init shifter doubles as the solution register; CALC overwrites it with u_new.
  pe_shift_in #(.W(W)) u_sol (
    .clka(clka), .rst_n(rst_n), .en(state == ST_INIT), .din(init_bit),
    .load(state == ST_CALC), .load_val(u_new), .q(sol)
  );

  always_comb begin
    sum     = {2'b00, l_q} + {2'b00, t_q} + {2'b00, r_q} + {2'b00, d_q};
    sum_rnd = sum + (W+2)'(2 * ROUND);
    u_new   = sum_rnd[W+1:2];
    diff    = $signed({1'b0, u_new}) - $signed({1'b0, sol});
    mag     = diff[W] ? -diff : diff;
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      residue  <= 1'b0;
      iter_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (init) begin
            state    <= ST_INIT;
            residue  <= 1'b0;
            iter_cnt <= '0;
          end else if (start) begin
            state <= ST_LOAD;
          end
        end
        ST_INIT, ST_OUT: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= ST_CALC;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_CALC: begin
          residue <= (mag > (W+1)'(TOL));
          if (iter_cnt != '1) iter_cnt <= iter_cnt + ITER_W'(1);
          cnt   <= '0;
          state <= read_en ? ST_OUT : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // done in CALC has to follow read_en within the same cycle.
  assign busy      = (state != ST_IDLE);
  assign sol_valid = (state == ST_OUT);
  assign sol_bit   = (state == ST_OUT) ? sol[LAST - cnt] : 1'b0;
  assign done      = ((state == ST_OUT) && (cnt == LAST)) || ((state == ST_CALC) && !read_en);

endmodule

// File: tb/tb_pe_jacobi_serial.sv
// tb/tb_pe_jacobi_serial.sv - scoreboard bench for pe_jacobi_serial across three parameter sets
module tb_pe_jacobi_serial;

  logic clka = 1'b0;
  logic rst_n, init, init_bit, start, in_valid, left, top, right, down, read_en;
  logic [2:0] sb, sv, rs, bz, dn;
  logic [7:0] it0, it1;
  logic [1:0] it2;

  always #5 clka = ~clka;

  pe_jacobi_serial #(.W(8), .TOL(0), .ROUND(0), .ITER_W(8)) dut (
    .clka(clka), .rst_n(rst_n), .init(init), .init_bit(init_bit), .start(start),
    .in_valid(in_valid), .left(left), .top(top), .right(right), .down(down), .read_en(read_en),
    .sol_bit(sb[0]), .sol_valid(sv[0]), .residue(rs[0]), .busy(bz[0]), .done(dn[0]), .iter_cnt(it0));

  pe_jacobi_serial #(.W(8), .TOL(0), .ROUND(1), .ITER_W(8)) dut_r (
    .clka(clka), .rst_n(rst_n), .init(init), .init_bit(init_bit), .start(start),
    .in_valid(in_valid), .left(left), .top(top), .right(right), .down(down), .read_en(read_en),
    .sol_bit(sb[1]), .sol_valid(sv[1]), .residue(rs[1]), .busy(bz[1]), .done(dn[1]), .iter_cnt(it1));

  pe_jacobi_serial #(.W(8), .TOL(16), .ROUND(0), .ITER_W(2)) dut_s (
    .clka(clka), .rst_n(rst_n), .init(init), .init_bit(init_bit), .start(start),
    .in_valid(in_valid), .left(left), .top(top), .right(right), .down(down), .read_en(read_en),
    .sol_bit(sb[2]), .sol_valid(sv[2]), .residue(rs[2]), .busy(bz[2]), .done(dn[2]), .iter_cnt(it2));

  int n_cmp = 0;
  int n_bad = 0;

  // independent reference: per-instance rounding, tolerance and saturation limit
  int rnd_p[3]  = '{0, 1, 0};
  int tol_p[3]  = '{0, 0, 16};
  int imax_p[3] = '{255, 255, 3};
  int m_sol[3], m_iter[3], m_res[3];

  int q0[$], q1[$];
  logic [7:0] acc0, acc1;
  int n0 = 0, n1 = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int act_iter(input int k);
    case (k)
      0: return int'(it0);
      1: return int'(it1);
      default: return int'(it2);
    endcase
  endfunction

  always @(negedge clka) begin
    if (sv[0]) begin
      acc0 = {acc0[6:0], sb[0]};
      n0++;
      if (n0 == 8) begin
        n0 = 0;
        if (q0.size() == 0) check("stream0_unexpected", 1, 0);
        else check("stream0", acc0, q0.pop_front());
      end
    end
    if (sv[1]) begin
      acc1 = {acc1[6:0], sb[1]};
      n1++;
      if (n1 == 8) begin
        n1 = 0;
        if (q1.size() == 0) check("stream1_unexpected", 1, 0);
        else check("stream1", acc1, q1.pop_front());
      end
    end
  end

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_sol[k] = 0; m_iter[k] = 0; m_res[k] = 0;
    end
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_res%0d", tag, k), rs[k], m_res[k]);
      check($sformatf("%s_iter%0d", tag, k), act_iter(k), m_iter[k]);
      check($sformatf("%s_busy%0d", tag, k), bz[k], 0);
    end
  endtask

  task automatic do_init(input logic [7:0] v);
    @(negedge clka);
    init = 1'b1; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clka);
      init = 1'b0; start = 1'b0; init_bit = v[7-i];
    end
    @(negedge clka);
    init_bit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_sol[k] = int'(v); m_iter[k] = 0; m_res[k] = 0;
    end
    check_state("init");
  endtask

  task automatic run_frame(input logic [7:0] l, t, r, d, input bit rd, input int gap, input bit poke);
    int cyc, done_cyc, ai, g, e, df;
    bit vis;
    for (int k = 0; k < 3; k++) begin
      e  = (int'(l) + int'(t) + int'(r) + int'(d) + 2 * rnd_p[k]) / 4;
      df = (e > m_sol[k]) ? e - m_sol[k] : m_sol[k] - e;
      m_res[k] = (df > tol_p[k]) ? 1 : 0;
      m_sol[k] = e;
      if (m_iter[k] < imax_p[k]) m_iter[k]++;
    end
    if (rd) begin
      q0.push_back(m_sol[0]);
      q1.push_back(m_sol[1]);
    end
    @(negedge clka);
    start = 1'b1; read_en = rd;
    cyc = 0; done_cyc = -1; ai = 0; g = 0; vis = 1'b0;
    while (cyc < 60 && done_cyc < 0) begin
      @(negedge clka);
      cyc++;
      if (dn[0]) begin
        done_cyc = cyc;
        check("done_all", int'(dn), 7);
      end
      if (sv[0]) vis = 1'b1;
      start = poke && (cyc == 12);
      if (ai < 8 && !(ai == 4 && g < gap)) begin
        in_valid = 1'b1;
        left = l[7-ai]; top = t[7-ai]; right = r[7-ai]; down = d[7-ai];
        ai++;
      end else begin
        in_valid = 1'b0;
        if (ai == 4) g++;
      end
    end
    check("done_cycle", done_cyc, (rd ? 17 : 9) + gap);
    if (!rd) check("no_sol_valid", int'(vis), 0);
    @(negedge clka);
    start = 1'b0;
    check_state("frame");
  endtask

  initial begin
    rst_n = 1'b0; init = 1'b0; init_bit = 1'b0; start = 1'b0; in_valid = 1'b0;
    left = 1'b0; top = 1'b0; right = 1'b0; down = 1'b0; read_en = 1'b0;
    model_reset();
    repeat (2) @(negedge clka);
    check("rst_busy", int'(bz), 0);
    check("rst_done", int'(dn), 0);
    check("rst_sol_valid", int'(sv), 0);
    check("rst_sol_bit", int'(sb), 0);
    check("rst_residue", int'(rs), 0);
    check("rst_iter", int'(it0), 0);
    rst_n = 1'b1;

    do_init(8'h00);
    run_frame(8'hE4, 8'hE7, 8'hB0, 8'hCC, 1'b1, 0, 1'b0);
    run_frame(8'hE4, 8'hE7, 8'hB0, 8'hCC, 1'b0, 0, 1'b0);
    run_frame(8'hE4, 8'hE7, 8'hB0, 8'hCC, 1'b1, 3, 1'b0);
    run_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    run_frame(8'hE4, 8'hE7, 8'hB0, 8'hCC, 1'b1, 0, 1'b0);
    run_frame(8'hC5, 8'hC5, 8'hC5, 8'hC5, 1'b0, 0, 1'b0);

    // abort a frame after four accepted bits
    @(negedge clka);
    start = 1'b1; read_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clka);
      start = 1'b0; in_valid = 1'b1; left = 1'b1; top = 1'b0; right = 1'b1; down = 1'b1;
    end
    @(negedge clka);
    in_valid = 1'b0;
    check("mid_load_busy", int'(bz), 7);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(bz), 0);
    check("abort_done", int'(dn), 0);
    check("abort_sol_valid", int'(sv), 0);
    check("abort_sol_bit", int'(sb), 0);
    check("abort_residue", int'(rs), 0);
    check("abort_iter0", int'(it0), 0);
    check("abort_iter2", int'(it2), 0);
    model_reset();
    @(negedge clka);
    rst_n = 1'b1;

    run_frame(8'hE4, 8'hE7, 8'hB0, 8'hCC, 1'b1, 0, 1'b1);
    repeat (3) begin
      @(negedge clka);
      check("start_in_out_ignored", int'(bz), 0);
    end

    do_init(8'h30);
    run_frame(8'h30, 8'h30, 8'h30, 8'h30, 1'b1, 0, 1'b0);

    repeat (2) @(negedge clka);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
